residual_relu_engine: RTL and testbench

Post-processing engine between the output (psum) SRAM and a result SRAM. It sequences reads of N psum words and N matching residual words, adds per lane, saturates, optionally applies ReLU, and writes results back at one word per clock. It is the parametrised hardware replacement for the residual-add/ReLU check that today runs outside the core. It adds saturation, a residual-sign mode and bypass modes.

---
 rtl/residual_relu_engine.sv | 157 +++++++++++++++
 tb/tb_residual_relu_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/residual_relu_engine.sv
// Residual-add / saturate / ReLU engine: streams N psum + residual words from SRAM,
// combines them per lane and writes one result word per clock.

module residual_relu_lane #(
    parameter int PSUM_W     = 16,
    parameter int RES_W      = 4,
    parameter int RES_SIGNED = 0
) (
    input  logic [PSUM_W-1:0] p,
    input  logic [RES_W-1:0]  r,
    input  logic              res_en,
    input  logic              relu_en,
    output logic [PSUM_W-1:0] y,
    output logic              sat
);
    localparam logic [PSUM_W-1:0] MAX_V = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] MIN_V = {1'b1, {(PSUM_W-1){1'b0}}};

    logic [PSUM_W:0]   r_ext, s;
    logic [PSUM_W-1:0] c;

    always_comb begin
        r_ext = '0;
        if (res_en) begin
            if (RES_SIGNED != 0) r_ext = {{(PSUM_W+1-RES_W){r[RES_W-1]}}, r};
            else                 r_ext = {{(PSUM_W+1-RES_W){1'b0}}, r};
        end
        s   = {p[PSUM_W-1], p} + r_ext;
        // The extra sign bit disagreeing with the lane MSB means the sum left range.
        sat = s[PSUM_W] ^ s[PSUM_W-1];
        c   = sat ? (s[PSUM_W] ? MIN_V : MAX_V) : s[PSUM_W-1:0];
        y   = (relu_en && c[PSUM_W-1]) ? '0 : c;
    end
endmodule

module residual_relu_engine #(
    parameter int LANES      = 8,
    parameter int PSUM_W     = 16,
    parameter int RES_W      = 4,
    parameter int ADDR_W     = 4,
    parameter int RES_SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W:0]         num_words,
    input  logic                    res_en,
    input  logic                    relu_en,
    output logic                    busy,
    output logic                    done,
    output logic                    psum_cen,
    output logic [ADDR_W-1:0]       psum_addr,
    input  logic [LANES*PSUM_W-1:0] psum_q,
    output logic                    res_cen,
    output logic [ADDR_W-1:0]       res_addr,
    input  logic [LANES*RES_W-1:0]  res_q,
    output logic                    out_cen,
    output logic                    out_wen,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [LANES*PSUM_W-1:0] out_d,
    output logic [ADDR_W+3:0]       sat_count
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W:0]                n_q;
    logic                           res_en_q, relu_en_q;
    logic [ADDR_W-1:0]              rd_addr, q_addr;
    logic [1:0]                     vld_pipe;  // [0]: SRAM data valid, [1]: write cycle
    logic                           rd_go, last_rd, accept;
    logic [LANES-1:0][PSUM_W-1:0]   lane_y;
    logic [LANES-1:0]               sat_vec;
    logic [ADDR_W+4:0]              pop, sat_sum;

    assign rd_go   = (state == READ);
    assign last_rd = rd_go && ({1'b0, rd_addr} == n_q - 1'b1);
    assign accept  = (state == IDLE) && start;

    assign busy      = (state == READ) || (state == DRAIN);
    assign done      = (state == FIN);
    assign psum_cen  = ~rd_go;
    assign res_cen   = ~(rd_go && res_en_q);
    assign psum_addr = rd_addr;
    assign res_addr  = rd_addr;
    assign out_cen   = ~vld_pipe[1];
    assign out_wen   = ~vld_pipe[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (num_words == '0) ? FIN : READ;
            READ:  if (last_rd) state_nxt = DRAIN;
            DRAIN: if (vld_pipe[1] && !vld_pipe[0]) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
            residual_relu_lane #(
                .PSUM_W(PSUM_W), .RES_W(RES_W), .RES_SIGNED(RES_SIGNED)
            ) u_lane (
                .p      (psum_q[j*PSUM_W +: PSUM_W]),
                .r      (res_q[j*RES_W +: RES_W]),
                .res_en (res_en_q),
                .relu_en(relu_en_q),
                .y      (lane_y[j]),
                .sat    (sat_vec[j])
            );
        end
    endgenerate

    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++) pop = pop + {{(ADDR_W+4){1'b0}}, sat_vec[k]};
        sat_sum = {1'b0, sat_count} + pop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q       <= '0;
            res_en_q  <= 1'b0;
            relu_en_q <= 1'b0;
            rd_addr   <= '0;
            q_addr    <= '0;
            vld_pipe  <= '0;
            out_addr  <= '0;
            out_d     <= '0;
            sat_count <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], rd_go};
            if (accept) begin
                n_q       <= num_words;
                res_en_q  <= res_en;
                relu_en_q <= relu_en;
                sat_count <= '0;
                // Empty runs touch no SRAM, so the address keeps its last value.
                if (num_words != '0) rd_addr <= '0;
            end else if (rd_go && !last_rd) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (rd_go) q_addr <= rd_addr;
            if (vld_pipe[0]) begin
                out_d     <= lane_y;
                out_addr  <= q_addr;
                sat_count <= sat_sum[ADDR_W+4] ? '1 : sat_sum[ADDR_W+3:0];
            end
        end
    end
endmodule

// File: tb/tb_residual_relu_engine.sv
// Directed bench: two engines (zero- and sign-extended residual) on shared SRAM models.

module tb_residual_relu_engine;
    localparam int LANES = 8, PSUM_W = 16, RES_W = 4, ADDR_W = 4;
    localparam int DW = LANES*PSUM_W, RW = LANES*RES_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, res_en, relu_en;
    logic [ADDR_W:0]   num_words;
    logic              busy[2], done[2], psum_cen[2], res_cen[2], out_cen[2], out_wen[2];
    logic [ADDR_W-1:0] psum_addr[2], res_addr[2], out_addr[2];
    logic [DW-1:0]     psum_q[2], out_d[2];
    logic [RW-1:0]     res_q[2];
    logic [ADDR_W+3:0] sat_count[2];

    residual_relu_engine #(.LANES(LANES), .PSUM_W(PSUM_W), .RES_W(RES_W), .ADDR_W(ADDR_W), .RES_SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words), .res_en(res_en), .relu_en(relu_en),
        .busy(busy[0]), .done(done[0]), .psum_cen(psum_cen[0]), .psum_addr(psum_addr[0]), .psum_q(psum_q[0]),
        .res_cen(res_cen[0]), .res_addr(res_addr[0]), .res_q(res_q[0]), .out_cen(out_cen[0]), .out_wen(out_wen[0]),
        .out_addr(out_addr[0]), .out_d(out_d[0]), .sat_count(sat_count[0]));

    residual_relu_engine #(.LANES(LANES), .PSUM_W(PSUM_W), .RES_W(RES_W), .ADDR_W(ADDR_W), .RES_SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words), .res_en(res_en), .relu_en(relu_en),
        .busy(busy[1]), .done(done[1]), .psum_cen(psum_cen[1]), .psum_addr(psum_addr[1]), .psum_q(psum_q[1]),
        .res_cen(res_cen[1]), .res_addr(res_addr[1]), .res_q(res_q[1]), .out_cen(out_cen[1]), .out_wen(out_wen[1]),
        .out_addr(out_addr[1]), .out_d(out_d[1]), .sat_count(sat_count[1]));

    logic [DW-1:0] pmem[16];
    logic [RW-1:0] rmem[16];
    logic [DW-1:0] omem[2][16];
    int  wr_cnt[2], first_wc[2], last_wc[2], addr_err[2], done_cnt[2], done_cyc[2];
    bit  cen_low[2], rcen_low[2];
    time t0;
    int  n_chk = 0, n_fail = 0;

    // SRAM models: one-cycle read latency, writes captured with the cycle they occur in.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!psum_cen[d]) psum_q[d] <= pmem[psum_addr[d]];
            if (!res_cen[d])  res_q[d]  <= rmem[res_addr[d]];
            if (!psum_cen[d] || !res_cen[d] || !out_cen[d]) cen_low[d] = 1'b1;
            if (!res_cen[d]) rcen_low[d] = 1'b1;
            if (!out_cen[d] && !out_wen[d]) begin
                int c;
                c = int'(($time - t0) / 10);
                omem[d][out_addr[d]] = out_d[d];
                if (wr_cnt[d] == 0) first_wc[d] = c;
                last_wc[d] = c;
                if (int'(out_addr[d]) != c - 3) addr_err[d]++;
                wr_cnt[d]++;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            if (done[d]) begin
                done_cnt[d]++;
                done_cyc[d] = int'(($time - t0 + 5) / 10);
            end
    end

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic kick(input int n, input logic re, input logic rl);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0; first_wc[d] = -1; last_wc[d] = -1; addr_err[d] = 0;
            done_cnt[d] = 0; done_cyc[d] = -1; cen_low[d] = 1'b0; rcen_low[d] = 1'b0;
        end
        num_words = (ADDR_W+1)'(n); res_en = re; relu_en = rl; start = 1'b1;
        @(posedge clk);
        t0 = $time;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n);
        int i = 0;
        while (!done[0] && i < n + 10) begin
            @(negedge clk);
            i++;
        end
        chk({tag, " done seen"}, DW'(done[0]), DW'(1));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; num_words = '0; res_en = 1'b0; relu_en = 1'b0; t0 = 0;
        for (int d = 0; d < 2; d++) for (int a = 0; a < 16; a++) omem[d][a] = '0;
        repeat (3) @(negedge clk);
        chk("rst busy/done", DW'({busy[0], done[0]}), DW'(0));
        chk("rst cens", DW'({psum_cen[0], res_cen[0], out_cen[0], out_wen[0]}), DW'(4'hF));
        chk("rst addrs", DW'({psum_addr[0], res_addr[0], out_addr[0]}), DW'(0));
        chk("rst out_d/sat", out_d[0] | DW'(sat_count[0]), DW'(0));
        reset = 1'b1;

        // -3 + 5 = 2 in every lane, full address range.
        for (int a = 0; a < 16; a++) begin pmem[a] = {LANES{16'hFFFD}}; rmem[a] = {LANES{4'h5}}; end
        kick(16, 1'b1, 1'b1);
        chk("t1 busy", DW'(busy[0]), DW'(1));
        wait_done("t1", 16);
        begin
            int bad = 0;
            for (int a = 0; a < 16; a++) if (omem[0][a] !== {LANES{16'h0002}}) bad++;
            chk("t1 bad words", DW'(bad), DW'(0));
        end
        chk("t1 word15 signed", omem[1][15], {LANES{16'h0002}});
        chk("t1 writes", DW'(wr_cnt[0]), DW'(16));
        chk("t1 first/last wr cyc", DW'({first_wc[0][7:0], last_wc[0][7:0]}), DW'({8'd3, 8'd18}));
        chk("t1 addr order", DW'(addr_err[0]), DW'(0));
        chk("t1 done cyc", DW'(done_cyc[0]), DW'(19));
        chk("t1 sat", DW'(sat_count[0]), DW'(0));

        // Positive saturation on lane 0 (unsigned residual); signed residual subtracts instead.
        for (int a = 0; a < 16; a++) begin pmem[a] = {112'h0, 16'h7FFE}; rmem[a] = {28'h0, 4'hF}; end
        kick(4, 1'b1, 1'b1);
        wait_done("t2", 4);
        chk("t2 word0", omem[0][0], {112'h0, 16'h7FFF});
        chk("t2 word3", omem[0][3], {112'h0, 16'h7FFF});
        chk("t2 sat", DW'(sat_count[0]), DW'(4));
        chk("t2 signed word", omem[1][2], {112'h0, 16'h7FFD});
        chk("t2 signed sat", DW'(sat_count[1]), DW'(0));

        // Negative saturation with sign-extended residual, without then with ReLU.
        pmem[0] = {112'h0, 16'h8000}; rmem[0] = {28'h0, 4'hF};
        kick(1, 1'b1, 1'b0);
        wait_done("t3a", 1);
        chk("t3a signed word", omem[1][0], {112'h0, 16'h8000});
        chk("t3a signed sat", DW'(sat_count[1]), DW'(1));
        chk("t3a unsigned word", omem[0][0], {112'h0, 16'h800F});
        chk("t3a unsigned sat", DW'(sat_count[0]), DW'(0));
        kick(1, 1'b1, 1'b1);
        wait_done("t3b", 1);
        chk("t3b relu words", {omem[1][0][63:0], omem[0][0][63:0]}, DW'(0));

        // Residual disabled: psum passes through, residual SRAM never enabled.
        for (int a = 0; a < 16; a++) begin pmem[a] = {LANES{16'hFFF9}}; rmem[a] = '1; end
        kick(3, 1'b0, 1'b0);
        wait_done("t4", 3);
        chk("t4 word2", omem[0][2], {LANES{16'hFFF9}});
        chk("t4 signed word1", omem[1][1], {LANES{16'hFFF9}});
        chk("t4 res_cen low", DW'({rcen_low[1], rcen_low[0]}), DW'(0));

        // Empty run, then a start pulse during an 8-word run.
        kick(0, 1'b1, 1'b0);
        wait_done("t5a", 0);
        chk("t5a done cyc", DW'(done_cyc[0]), DW'(1));
        chk("t5a no cen", DW'(cen_low[0]), DW'(0));
        kick(8, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        num_words = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5b", 8);
        chk("t5b writes", DW'(wr_cnt[0]), DW'(8));
        chk("t5b done cyc", DW'(done_cyc[0]), DW'(11));

        // Reset mid-run aborts immediately; a fresh run afterwards completes.
        kick(16, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6 cens in reset", DW'({psum_cen[0], res_cen[0], out_cen[0], out_wen[0]}), DW'(4'hF));
        chk("t6 busy in reset", DW'(busy[0]), DW'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        chk("t6 no done", DW'(done_cnt[0]), DW'(0));
        kick(2, 1'b1, 1'b1);
        wait_done("t6 rerun", 2);
        chk("t6 rerun writes", DW'(wr_cnt[0]), DW'(2));
        chk("t6 rerun done cyc", DW'(done_cyc[0]), DW'(5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
